oled_window_compositor: RTL

- Raster scheduler that shares one parent video raster (e.g. 1280x800) between two emulated OLED panel windows, plus a background colour.
- Tracks the raster position and decides, per pixel, which window owns it. It issues that window a render request with window-local coordinates, then muxes the returned pixel into the output stream.
- Sits between the video timing generator and the per-panel OLED emulator instances; window placement is latched once per frame.

---
 rtl/oled_window_compositor_pkg.sv | 28 ++
 rtl/oled_window_compositor_if.sv | 44 ++++
 rtl/oled_window_hit.sv | 32 +++
 rtl/oled_window_compositor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/oled_window_compositor_pkg.sv
// Shared types and constants for the two-window OLED raster compositor.
package oled_window_compositor_pkg;

   localparam int unsigned COORD_W = 13;
   localparam int unsigned HIT_W   = 14;
   localparam int unsigned PIX_W   = 32;

   localparam logic [PIX_W-1:0] COLOR_BLANK = 32'h0000_0000;

   typedef enum logic [0:0] {
      WAIT_FRAME = 1'b0,
      ACTIVE     = 1'b1
   } comp_state_e;

   typedef struct packed {
      logic [1:0] hit;
      logic       de;
      logic       hs;
      logic       vs;
   } raster_flags_t;

   // The extra MSB flags a coordinate left of / above the window origin.
   function automatic logic [HIT_W-1:0] coord_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

endpackage

// File: rtl/oled_window_compositor_if.sv
// Raster-in / window-request / pixel-out bundle of the window compositor.
interface oled_window_compositor_if;
   import oled_window_compositor_pkg::*;

   logic               raster_h_synk;
   logic               raster_v_synk;
   logic               raster_de;
   logic [1:0]         win_en;
   logic [COORD_W-1:0] win0_x0;
   logic [COORD_W-1:0] win0_y0;
   logic [COORD_W-1:0] win1_x0;
   logic [COORD_W-1:0] win1_y0;
   logic [PIX_W-1:0]   bg_color;
   logic [PIX_W-1:0]   win0_d_in;
   logic [PIX_W-1:0]   win1_d_in;

   logic [1:0]         win_req;
   logic [COORD_W-1:0] win0_x;
   logic [COORD_W-1:0] win0_y;
   logic [COORD_W-1:0] win1_x;
   logic [COORD_W-1:0] win1_y;
   logic [PIX_W-1:0]   pixel_out;
   logic               de_out;
   logic               h_synk_out;
   logic               v_synk_out;
   logic               frame_start;

   modport master (
      output raster_h_synk, raster_v_synk, raster_de, win_en,
             win0_x0, win0_y0, win1_x0, win1_y0,
             bg_color, win0_d_in, win1_d_in,
      input  win_req, win0_x, win0_y, win1_x, win1_y,
             pixel_out, de_out, h_synk_out, v_synk_out, frame_start
   );

   modport slave (
      input  raster_h_synk, raster_v_synk, raster_de, win_en,
             win0_x0, win0_y0, win1_x0, win1_y0,
             bg_color, win0_d_in, win1_d_in,
      output win_req, win0_x, win0_y, win1_x, win1_y,
             pixel_out, de_out, h_synk_out, v_synk_out, frame_start
   );

endinterface

// File: rtl/oled_window_hit.sv
// Per-window hit test: decides whether the raster position lies inside the window.
module oled_window_hit
   import oled_window_compositor_pkg::*;
#(
   parameter logic [COORD_W-1:0] WIN_W = 13'd512,
   parameter logic [COORD_W-1:0] WIN_H = 13'd256
) (
   input  logic               en_i,
   input  logic               de_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   input  logic [COORD_W-1:0] x0_i,
   input  logic [COORD_W-1:0] y0_i,
   output logic               hit_o,
   output logic [COORD_W-1:0] lx_o,
   output logic [COORD_W-1:0] ly_o
);

   logic [HIT_W-1:0] dx;
   logic [HIT_W-1:0] dy;

   always_comb begin
      dx    = coord_diff(x_i, x0_i);
      dy    = coord_diff(y_i, y0_i);
      hit_o = en_i & de_i
            & ~dx[HIT_W-1] & (dx < {1'b0, WIN_W})
            & ~dy[HIT_W-1] & (dy < {1'b0, WIN_H});
      lx_o  = dx[COORD_W-1:0];
      ly_o  = dy[COORD_W-1:0];
   end

endmodule

// File: rtl/oled_window_compositor.sv
// Shares one parent raster between two emulated OLED windows over a background colour.
module oled_window_compositor
   import oled_window_compositor_pkg::*;
#(
   parameter logic [COORD_W-1:0] WIN_W       = 13'd512,
   parameter logic [COORD_W-1:0] WIN_H       = 13'd256,
   parameter int unsigned        WIN_LATENCY = 1,
   parameter logic [COORD_W-1:0] X_MAX       = 13'd1279,
   parameter logic [COORD_W-1:0] Y_MAX       = 13'd799
) (
   input logic                     rst,
   input logic                     raster_clk,
   oled_window_compositor_if.slave bus
);

   comp_state_e        state_q;
   logic [1:0]         sh_en_q;
   logic [COORD_W-1:0] sh_w0x0_q, sh_w0y0_q, sh_w1x0_q, sh_w1y0_q;
   logic               frame_start_q;
   logic               vs_prev_q, de_prev_q;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               vs_rise;

   logic               hit0, hit1;
   logic [COORD_W-1:0] lx0, ly0, lx1, ly1;
   logic [1:0]         req_d;
   logic [COORD_W-1:0] w0x_q, w0y_q, w1x_q, w1y_q;

   raster_flags_t      flags_q [WIN_LATENCY+1];
   raster_flags_t      tap;
   logic [PIX_W-1:0]   pix_q;
   logic               de_out_q, hs_out_q, vs_out_q;

   assign vs_rise = bus.raster_v_synk & ~vs_prev_q;

   // Syncs take precedence over de when both are high in one cycle.
   always_comb begin
      x_d = x_q;
      if (bus.raster_h_synk)
         x_d = '0;
      else if (bus.raster_de && (x_q != X_MAX))
         x_d = x_q + 13'd1;

      y_d = y_q;
      if (bus.raster_v_synk)
         y_d = '0;
      else if (de_prev_q && !bus.raster_de && (y_q != Y_MAX))
         y_d = y_q + 13'd1;
   end

   always_ff @(posedge raster_clk or posedge rst) begin
      if (rst) begin
         x_q       <= '0;
         y_q       <= '0;
         vs_prev_q <= 1'b0;
         de_prev_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         vs_prev_q <= bus.raster_v_synk;
         de_prev_q <= bus.raster_de;
      end
   end

   // Both states reload the shadows on a v_synk rising edge; WAIT_FRAME only gates requests.
   always_ff @(posedge raster_clk or posedge rst) begin
      if (rst) begin
         state_q       <= WAIT_FRAME;
         sh_en_q       <= '0;
         sh_w0x0_q     <= '0;
         sh_w0y0_q     <= '0;
         sh_w1x0_q     <= '0;
         sh_w1y0_q     <= '0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         unique case (state_q)
            WAIT_FRAME, ACTIVE: begin
               if (vs_rise) begin
                  state_q       <= ACTIVE;
                  sh_en_q       <= bus.win_en;
                  sh_w0x0_q     <= bus.win0_x0;
                  sh_w0y0_q     <= bus.win0_y0;
                  sh_w1x0_q     <= bus.win1_x0;
                  sh_w1y0_q     <= bus.win1_y0;
                  frame_start_q <= 1'b1;
               end
            end
            default: state_q <= WAIT_FRAME;
         endcase
      end
   end

   oled_window_hit #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_hit0 (
      .en_i (sh_en_q[0]),
      .de_i (bus.raster_de),
      .x_i  (x_q),
      .y_i  (y_q),
      .x0_i (sh_w0x0_q),
      .y0_i (sh_w0y0_q),
      .hit_o(hit0),
      .lx_o (lx0),
      .ly_o (ly0)
   );

   oled_window_hit #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_hit1 (
      .en_i (sh_en_q[1]),
      .de_i (bus.raster_de),
      .x_i  (x_q),
      .y_i  (y_q),
      .x0_i (sh_w1x0_q),
      .y0_i (sh_w1y0_q),
      .hit_o(hit1),
      .lx_o (lx1),
      .ly_o (ly1)
   );

   assign req_d = (state_q == ACTIVE) ? {hit1, hit0} : 2'b00;

   // flags_q[0] is the stage-1 register; the tail aligns flags with the returned pixel.
   always_ff @(posedge raster_clk or posedge rst) begin
      if (rst) begin
         w0x_q <= '0;
         w0y_q <= '0;
         w1x_q <= '0;
         w1y_q <= '0;
         for (int unsigned i = 0; i <= WIN_LATENCY; i++)
            flags_q[i] <= '0;
      end else begin
         if (req_d[0]) begin
            w0x_q <= lx0;
            w0y_q <= ly0;
         end
         if (req_d[1]) begin
            w1x_q <= lx1;
            w1y_q <= ly1;
         end
         flags_q[0] <= '{hit: req_d, de: bus.raster_de,
                         hs: bus.raster_h_synk, vs: bus.raster_v_synk};
         for (int unsigned i = 1; i <= WIN_LATENCY; i++)
            flags_q[i] <= flags_q[i-1];
      end
   end

   assign tap = flags_q[WIN_LATENCY];

   always_ff @(posedge raster_clk or posedge rst) begin
      if (rst) begin
         pix_q    <= '0;
         de_out_q <= 1'b0;
         hs_out_q <= 1'b0;
         vs_out_q <= 1'b0;
      end else begin
         de_out_q <= tap.de;
         hs_out_q <= tap.hs;
         vs_out_q <= tap.vs;
         if (!tap.de)
            pix_q <= COLOR_BLANK;
         else if (tap.hit[0])
            pix_q <= bus.win0_d_in;
         else if (tap.hit[1])
            pix_q <= bus.win1_d_in;
         else
            pix_q <= bus.bg_color;
      end
   end

   assign bus.win_req     = flags_q[0].hit;
   assign bus.win0_x      = w0x_q;
   assign bus.win0_y      = w0y_q;
   assign bus.win1_x      = w1x_q;
   assign bus.win1_y      = w1y_q;
   assign bus.pixel_out   = pix_q;
   assign bus.de_out      = de_out_q;
   assign bus.h_synk_out  = hs_out_q;
   assign bus.v_synk_out  = vs_out_q;
   assign bus.frame_start = frame_start_q;

endmodule
